// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU,
//               with pipeline stall, flush and divide-by-zero/overflow fast path.
// Revision    : 1.0
// ============================================================================
module div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_int_min   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  c_all_ones  = {XLEN{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic             r_rem_sel;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [XLEN-1:0]  r_dvd;
    logic [XLEN-1:0]  r_dsr;
    logic [XLEN:0]    r_rem;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_result;

    logic             w_accept;
    logic             w_sign_op;
    logic             w_div0;
    logic             w_ovf;
    logic             w_fast;
    logic [XLEN-1:0]  w_fast_res;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic [XLEN:0]    w_rem_sh;
    logic             w_ge;
    logic [XLEN-1:0]  w_q_fix;
    logic [XLEN-1:0]  w_r_fix;
    logic             w_unused;

    assign w_unused  = func3[2];
    assign w_accept  = (r_state == S_IDLE) && start && !flush;
    assign w_sign_op = ~func3[0];
    assign w_div0    = (src2 == '0);
    assign w_ovf     = w_sign_op && (src1 == c_int_min) && (src2 == c_all_ones);
    assign w_fast    = w_div0 || w_ovf;

    // Divide-by-zero returns the raw dividend as remainder; overflow yields INT_MIN / 0.
    always_comb begin
        w_fast_res = '0;
        if (w_div0)
            w_fast_res = func3[1] ? src1 : c_all_ones;
        else
            w_fast_res = func3[1] ? '0 : c_int_min;
    end

    // INT_MIN negates to itself, which is the correct unsigned magnitude.
    assign w_a_mag = (w_sign_op && src1[XLEN-1]) ? -src1 : src1;
    assign w_b_mag = (w_sign_op && src2[XLEN-1]) ? -src2 : src2;

    assign w_rem_sh = {r_rem[XLEN-1:0], r_dvd[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dsr});
    assign w_q_fix  = r_neg_q ? -r_dvd : r_dvd;
    assign w_r_fix  = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_next = w_fast ? S_DONE : S_CALC;
                S_CALC: if (r_count == c_last_step) w_next = S_FIX;
                S_FIX:  w_next = S_DONE;
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = (r_state != S_IDLE);
        done  = (r_state == S_DONE);
        stall = w_accept || (busy && !done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem_sel <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_rem     <= '0;
            r_count   <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_rem_sel <= func3[1];
            r_neg_q   <= w_sign_op && (src1[XLEN-1] ^ src2[XLEN-1]);
            r_neg_r   <= w_sign_op && src1[XLEN-1];
            r_dvd     <= w_a_mag;
            r_dsr     <= w_b_mag;
            r_rem     <= '0;
            r_count   <= '0;
            if (w_fast)
                r_result <= w_fast_res;
        end else if (r_state == S_CALC) begin
            r_rem   <= w_ge ? (w_rem_sh - {1'b0, r_dsr}) : w_rem_sh;
            r_dvd   <= {r_dvd[XLEN-2:0], w_ge};
            r_count <= r_count + CNT_W'(1);
        end else if ((r_state == S_FIX) && !flush) begin
            r_result <= r_rem_sel ? w_r_fix : w_q_fix;
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sequencer
// Description : Scoreboard bench for div_sequencer using directed vectors.
// Revision    : 1.0
// ============================================================================
module tb_div_sequencer;

    localparam logic [2:0] c_div  = 3'b100;
    localparam logic [2:0] c_divu = 3'b101;
    localparam logic [2:0] c_rem  = 3'b110;
    localparam logic [2:0] c_remu = 3'b111;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  func3 = '0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   c0;
    exp_t exp_q[$];

    div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .func3(func3), .src1(src1),
        .src2(src2), .flush(flush), .busy(busy), .stall(stall), .done(done),
        .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got result 0x%08h expected no done (cycle %0d)", result, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("done_cycle", cyc, e.cyc);
                check("stall_in_done", {31'b0, stall}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 (cycle %0d)", cyc);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int lat, input bit push);
        @(negedge clk);
        wait_idle();
        func3 = f;
        src1  = a;
        src2  = b;
        start = 1'b1;
        c0    = cyc;
        if (push) exp_q.push_back('{res: exp_res, cyc: cyc + lat});
        #1;
        check("stall_at_accept", {31'b0, stall}, 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;

        issue(c_divu, 32'd100, 32'd7, 32'd14, 34, 1'b1);
        issue(c_remu, 32'd100, 32'd7, 32'd2, 34, 1'b1);
        issue(c_div,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1);
        issue(c_rem,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b1);
        issue(c_rem,  32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b1);
        issue(c_div,  32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
        issue(c_remu, 32'd5, 32'd0, 32'd5, 1, 1'b1);
        issue(c_div,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
        issue(c_rem,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);
        issue(c_divu, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 1'b1);
        issue(c_remu, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b1);
        issue(c_div,  32'h8000_0000, 32'd2, 32'hC000_0000, 34, 1'b1);
        issue(c_divu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 1'b1);

        // Flush in cycle 10, then a fresh start in cycle 11.
        issue(c_divu, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_result_held", result, 32'hFFFF_FFFF);
        func3 = c_divu;
        src1  = 32'd1000;
        src2  = 32'd3;
        start = 1'b1;
        exp_q.push_back('{res: 32'd333, cyc: cyc + 34});
        @(negedge clk);
        start = 1'b0;
        check("post_flush_busy", {31'b0, busy}, 32'd1);

        // Reset in cycle 20 with start high.
        issue(c_divu, 32'd50, 32'd5, 32'd0, 0, 1'b0);
        repeat (19) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("rst20_busy", {31'b0, busy}, 32'd0);
        check("rst20_done", {31'b0, done}, 32'd0);
        check("rst20_stall", {31'b0, stall}, 32'd0);
        check("rst20_result", result, 32'd0);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("rst_start_ignored", {31'b0, busy}, 32'd0);

        // Flush with start in IDLE: no accept, no stall.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_start_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        check("flush_start_busy", {31'b0, busy}, 32'd0);

        begin
            int guard = 0;
            while (exp_q.size() != 0 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (exp_q.size() != 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
            end
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer and datapath for the M-extension divide group (DIV, DIVU, REM, REMU). It sits beside the single-cycle ALU in the EX stage. Divide-class instructions go to this block instead of the ALU. The block stalls the pipeline while a 32-step radix-2 restoring division runs, then presents the result for one cycle so EX can forward and write it back.

## Interface
Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX holds a valid divide-class instruction; sampled only in IDLE.
- func3  input  3  3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU; sampled with start.
- src1  input  XLEN  dividend; sampled with start.
- src2  input  XLEN  divisor; sampled with start.
- flush  input  1  kill the in-flight operation (branch mispredict or trap).
- busy  output  1  state != IDLE.
- stall  output  1  pipeline hold request (combinational).
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  XLEN  quotient or remainder; registered; held until the next accepted start.

## Operation
- States and transitions:
  - IDLE: start & ~flush → CALC, or → DONE on the fast path.
  - CALC: runs XLEN cycles, then → FIX.
  - FIX: → DONE.
  - DONE: → IDLE.
  - flush in any state → IDLE next cycle. done is suppressed and result is not updated.
- Accept (IDLE & start & ~flush):
  - latch func3.
  - sign_op = ~func3[0].
  - neg_q = sign_op & (src1[31] ^ src2[31]).
  - neg_r = sign_op & src1[31].
  - dividend and divisor are loaded as magnitudes when sign_op (two's-complement negate if bit 31 set; 0x80000000 stays 0x80000000 as unsigned).
  - remainder register (XLEN+1 bits) cleared; count = 0.
- Fast path, decided at accept; goes directly to DONE with result latched on the same edge:
  - Divisor zero: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = src1 unmodified.
  - Signed overflow (DIV/REM, src1 = 0x80000000, src2 = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- CALC, one restoring step per cycle:
  - rem = {rem[XLEN-1:0], dvd[XLEN-1]}; dvd <<= 1.
  - If rem ≥ divisor: rem -= divisor, dvd[0] = 1; else dvd[0] = 0.
  - count increments each step; after the step with count = XLEN-1, → FIX.
- FIX:
  - q = dvd, negated if neg_q.
  - r = rem[XLEN-1:0], negated if neg_r.
  - result ← q for func3[1] = 0, r for func3[1] = 1.
- start while busy is ignored. EX must keep start asserted only while stalled.
- stall = (IDLE & start & ~flush) | (busy & ~done).
- Reset values: state IDLE, busy 0, done 0, result 0, count 0, internal registers 0.

## Timing
- Accept edge ends cycle 0, the cycle with start high in IDLE.
- Normal latency:
  - CALC occupies cycles 1..32.
  - FIX is cycle 33.
  - done = 1 and result is valid in cycle 34.
  - stall is high in cycles 0..33 and low in cycle 34, so EX advances with the result.
- Fast path: stall is high in cycle 0; done = 1 with result valid in cycle 1.
- Back-to-back: a new start may be accepted in the cycle after done (IDLE). start in the done cycle itself is ignored.
- flush with start in IDLE: no accept, stall = 0.
- rst overrides flush and start.
- result holds its last value through IDLE, through flushed operations, and until the FIX edge (or fast-path accept edge) of the next operation.

## Test plan
- DIVU 100 / 7: start at cycle 0 → done in cycle 34, result 14. REMU with the same operands → 2.
- DIV -7 / 2 → result 0xFFFFFFFD (-3). REM -7 / 2 → 0xFFFFFFFF (-1). REM 7 / -2 → 1.
- Divide by zero, DIV 5 / 0 → result 0xFFFFFFFF. REMU 5 / 0 → 5. Both with done in cycle 1.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF → result 0x80000000 with done in cycle 1. REM with the same operands → 0.
- flush asserted in cycle 10 of a DIVU → busy 0 from cycle 11, no done pulse, result unchanged. A new start in cycle 11 is accepted normally.
- rst asserted in cycle 20 → all outputs at their reset values the next cycle. start in cycle 20 with rst high is not accepted.
